instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Front-end fetch initiator for the RV32 core: owns the program counter, issues word addresses to the instruction memory, and captures returned instructions. Instructions are buffered in a small queue and presented to decode with a valid/ready handshake, PC attached. Handles control-flow redirects from execute by flushing buffered and in-flight fetches. Sits between the instruction memory (fixed 1-cycle read latency) and the decode stage.

## Interface

- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, fetch queue entries (power of two, ≥2)

- clk  in  1  clock; all state on posedge
- reset  in  1  reset, synchronous, active-high
- imem_addr  out  32  word-aligned read address to instruction memory
- imem_req  out  1  address on imem_addr is a real fetch this cycle
- imem_rdata  in  32  instruction for the address issued the previous cycle
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_instr  out  32  instruction to decode
- if_pc  out  32  address of if_instr
- if_ready  in  1  decode accepts this cycle
- redirect_valid  in  1  execute-stage PC redirect (branch/jump/trap)
- redirect_pc  in  32  redirect target; bits [1:0] ignored

## Operation

- State: pc (next address to fetch), inflight bit + inflight_pc, inflight_kill bit, FIFO of {pc, instr}.
- imem_addr = {pc[31:2], 2'b00} continuously; imem_req combinational.
- Issue condition: imem_req = !redirect_valid && (count + inflight − deq) < DEPTH, where deq = if_valid && if_ready. On issue: inflight_pc ← pc, pc ← pc + 4 (32-bit wrap, 0xFFFF_FFFC → 0x0000_0000), inflight ← 1, inflight_kill ← 0; without issue inflight ← 0.
- Response: when inflight was set last cycle, imem_rdata is valid now; push {inflight_pc, imem_rdata} unless inflight_kill or redirect_valid this cycle.
- Queue: if_valid = count != 0; head drives if_instr/if_pc. Push and pop in same cycle allowed when full (pop frees slot). Push never occurs into a full queue by construction of the issue condition; simulation assertion fires otherwise.
- Redirect (redirect_valid=1): queue cleared, pc ← {redirect_pc[31:2],2'b00}, inflight_kill ← 1 for any outstanding response, no issue this cycle; if_valid still reflects pre-flush head this cycle but handshake with if_ready in the same cycle is treated as discarded. Fetch at target issues next cycle.
- Back-to-back redirects: latest wins; each kills responses from prior issues.
- Reset mid-operation: all state cleared regardless of inflight/redirect inputs.

## Timing

- Reset values: pc=RESET_PC, count=0, inflight=0, inflight_kill=0, if_valid=0, imem_req=0 during reset cycle, if_instr/if_pc=0.
- First fetch: imem_req=1 on first cycle after reset deasserts; if_valid=1 two cycles after reset deasserts (issue N, data at N+1, visible N+2).
- Latency issue → if_valid: 2 cycles. Redirect → first target instruction on if_valid: 3 cycles.
- Steady state with if_ready=1: one instruction per cycle, no bubbles (DEPTH ≥ 2).
- if_ready low: queue fills, issue stops when count+inflight = DEPTH; resumes same cycle a pop occurs.
- if_instr/if_pc stable while if_valid && !if_ready.

## Structure

- Shared package rv_fetch_pkg: RESET_PC default, NOP constant 32'h0000_0013, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module: fetch_queue (parameterised synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty; simultaneous push+pop when full legal).
- Top holds PC, inflight tracking, issue logic.

## Test plan

- Reset, memory words 0x00000013,0x00100093,0x00200113, if_ready=1 → imem_addr 0,4,8 on consecutive cycles; if_pc 0,4,8 with matching if_instr, one per cycle from cycle 2.
- if_ready=0 for 5 cycles from start → exactly DEPTH entries queued, imem_req low after 2 issues; release → PCs 0,4,8,... in order, none dropped or duplicated.
- redirect_valid with redirect_pc=0x40 while queue holds 0x8,0xC and fetch 0x10 inflight → none of 0x8/0xC/0x10 appear; next if_pc=0x40 three cycles later.
- redirect_pc=0x23 → fetch address 0x20.
- Redirect on two consecutive cycles (0x40 then 0x80) → 0x80 first delivered PC, 0x40 never delivered.
- Reset asserted while queue full and fetch inflight → if_valid=0 next cycle; refetch starts at RESET_PC; PC wrap test from redirect 0xFFFFFFFC → next PC 0x0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
package rv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; a push into a full queue is
// legal only when a pop happens in the same cycle.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: owns the PC, issues word fetches to a 1-cycle instruction
// memory, queues returned instructions for decode and handles redirects.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          inflight_kill;
  logic [31:0]   redirect_target;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          deq;
  logic          push;
  logic          pop;
  logic [AW+1:0] occupancy;
  fetch_entry_t  resp;
  fetch_entry_t  head;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr       = {pc[31:2], 2'b00};

  // A slot is reserved at issue time, so the queue can never overflow.
  assign deq       = if_valid && if_ready;
  assign occupancy = (AW+2)'(count) + (AW+2)'(inflight) - (AW+2)'(deq);
  assign imem_req  = !reset && !redirect_valid && (occupancy < (AW+2)'(DEPTH));

  // A decode handshake coinciding with a redirect is discarded with the flush.
  assign pop  = deq && !redirect_valid;
  assign push = inflight && !inflight_kill && !redirect_valid && (!full || pop);

  assign resp.pc    = inflight_pc;
  assign resp.instr = imem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_pc   <= '0;
      inflight_kill <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (redirect_valid) begin
        pc            <= redirect_target;
        inflight_kill <= 1'b1;
      end else if (imem_req) begin
        pc            <= imem_addr + 32'd4;
        inflight_pc   <= imem_addr;
        inflight_kill <= 1'b0;
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign if_valid = !empty;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected instruction stream pushed on
// reset/redirect, monitor compares every accepted instruction and fetch address.
module tb_instr_fetch_unit;
  import rv_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = NOP;
      32'h4:   mem_word = 32'h0010_0093;
      32'h8:   mem_word = 32'h0020_0113;
      default: mem_word = {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endcase
  endfunction

  // Instruction memory: fixed one-cycle read latency.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  fetch_entry_t sb_q[$];

  // The instruction stream decode must see after a reset or redirect.
  task automatic expect_stream(input logic [31:0] start);
    fetch_entry_t e;
    sb_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = mem_word(e.pc);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: outstanding-fetch count, fetch-address stream, deliveries.
  logic [31:0] m_fetch_pc = RPC;
  int          m_occ = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk) begin
    bit           hs;
    bit           exp_req;
    int           d;
    fetch_entry_t e;
    hs = if_valid && if_ready;
    if (reset) begin
      check(imem_req == 1'b0, "req_in_reset", 32'(imem_req), 32'd0);
      m_fetch_pc = RPC;
      m_occ      = 0;
      prev_stall = 0;
    end else if (redirect_valid) begin
      check(imem_req == 1'b0, "req_in_redirect", 32'(imem_req), 32'd0);
      m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      m_occ      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check(if_valid == 1'b1, "stall_valid", 32'(if_valid), 32'd1);
        check(if_pc == prev_pc, "stall_pc", if_pc, prev_pc);
        check(if_instr == prev_instr, "stall_instr", if_instr, prev_instr);
      end
      d = hs ? 1 : 0;
      exp_req = (m_occ - d) < DEPTH;
      check(imem_req == exp_req, "req_rule", 32'(imem_req), 32'(exp_req));
      if (imem_req) begin
        check(imem_addr == m_fetch_pc, "fetch_addr", imem_addr, m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_occ = m_occ + int'(imem_req) - d;
      if (hs) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "sb_underflow", if_pc, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check(if_pc == e.pc, "deliver_pc", if_pc, e.pc);
          check(if_instr == e.instr, "deliver_instr", if_instr, e.instr);
        end
      end
      prev_stall = if_valid && !if_ready;
      prev_pc    = if_pc;
      prev_instr = if_instr;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    expect_stream(RPC);
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int reqs;
    int r;
    expect_stream(RPC);
    // Reset state
    @(negedge clk);
    check(if_valid == 1'b0, "rst_valid", 32'(if_valid), 32'd0);
    check(if_pc == 32'd0, "rst_pc", if_pc, 32'd0);
    check(if_instr == 32'd0, "rst_instr", if_instr, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Streaming from reset with decode always ready
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) check(imem_req && imem_addr == 32'(4 * k), "start_addr", imem_addr, 32'(4 * k));
      if (k < 2) check(if_valid == 1'b0, "start_novalid", 32'(if_valid), 32'd0);
      else check(if_valid && if_pc == 32'(4 * (k - 2)) && if_instr == mem_word(32'(4 * (k - 2))),
                 "start_stream", if_pc, 32'(4 * (k - 2)));
      next_cycle();
    end

    // Decode stalled: queue fills to DEPTH and issue stops
    do_reset();
    if_ready = 1'b0;
    reqs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      reqs += int'(imem_req);
      next_cycle();
    end
    check(reqs == DEPTH, "stall_issue_count", 32'(reqs), 32'(DEPTH));
    @(negedge clk);
    check(if_valid && if_pc == 32'd0 && !imem_req, "stall_full_head", if_pc, 32'd0);
    next_cycle();
    if_ready = 1'b1;
    repeat (10) next_cycle();

    // Redirect with a queued head and a fetch in flight
    do_reset();
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    expect_stream(32'h40);
    @(negedge clk);
    check(if_valid && if_pc == 32'h8, "redir_preflush_head", if_pc, 32'h8);
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) check(imem_req && imem_addr == 32'h40, "redir_target_addr", imem_addr, 32'h40);
      if (k < 3) check(if_valid == 1'b0, "redir_bubble", 32'(if_valid), 32'd0);
      else check(if_valid && if_pc == 32'h40, "redir_latency", if_pc, 32'h40);
      next_cycle();
    end
    repeat (4) next_cycle();

    // Unaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h23;
    expect_stream(32'h20);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check(imem_req && imem_addr == 32'h20, "redir_align", imem_addr, 32'h20);
    repeat (5) next_cycle();

    // Back-to-back redirects: the later one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    expect_stream(32'h40);
    next_cycle();
    redirect_pc = 32'h80;
    expect_stream(32'h80);
    next_cycle();
    redirect_valid = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check(if_valid && if_pc == 32'h80, "redir_b2b_first", if_pc, 32'h80);
    repeat (4) next_cycle();

    // Reset with a full queue, redirect asserted at the same time
    if_ready = 1'b0;
    repeat (5) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    do_reset();
    redirect_valid = 1'b0;
    @(negedge clk);
    check(if_valid == 1'b0, "reset_flush_valid", 32'(if_valid), 32'd0);
    check(imem_req && imem_addr == RPC, "reset_refetch", imem_addr, RPC);
    next_cycle();
    if_ready = 1'b1;
    repeat (6) next_cycle();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    expect_stream(32'hFFFF_FFFC);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check(imem_addr == 32'hFFFF_FFFC, "wrap_first", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check(imem_req && imem_addr == 32'h0, "wrap_next", imem_addr, 32'h0);
    repeat (6) next_cycle();

    // Randomized traffic: decode stalls, redirects and occasional resets
    for (int c = 0; c < 800; c++) begin
      reset          = 1'b0;
      redirect_valid = 1'b0;
      if_ready       = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        expect_stream(RPC);
      end else if (r < 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        expect_stream(redirect_pc & 32'hFFFF_FFFC);
      end
      next_cycle();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    repeat (8) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
